// File: rtl/stack_burst_engine.sv
`default_nettype none
// ============================================================================
// stack_burst_engine: multi-word burst sequencer between a flat register-image
// bus and a single-port stack RAM. Optional macro: STACK_BURST_DESCEND_EN.
// Revision: 1.0
// ============================================================================
module stack_burst_engine #(
   parameter int DATA_W    = 16,
   parameter int ADDR_W    = 16,
   parameter int MAX_WORDS = 16,
   parameter int RD_LAT    = 1,
   parameter int CNT_W     = $clog2(MAX_WORDS + 1)
) (
   input  logic                        clock,
   input  logic                        reset_n,
   input  logic                        start,
   input  logic                        dir,
`ifdef STACK_BURST_DESCEND_EN
   input  logic                        descend,
`endif
   input  logic [ADDR_W-1:0]           base_addr,
   input  logic [CNT_W-1:0]            words,
   input  logic [DATA_W*MAX_WORDS-1:0] wdata_bus,
   output logic [DATA_W*MAX_WORDS-1:0] rdata_bus,
   output logic                        busy,
   output logic                        done,
   output logic                        err,
   output logic [ADDR_W-1:0]           ram_addr,
   output logic [DATA_W-1:0]           ram_wdata,
   output logic                        ram_wren,
   input  logic [DATA_W-1:0]           ram_q
);

   localparam int SEL_W = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WRITE  = 2'd1,
      READ   = 2'd2,
      FINISH = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   base_q, base_d;
   logic [CNT_W-1:0]    words_q, words_d;
   logic [CNT_W-1:0]    idx_q, idx_d;
   logic                desc_q, desc_d;
   logic                err_flag_q, err_flag_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
   logic                ram_wren_q, ram_wren_d;
   logic [DATA_W-1:0]   wslot_q [MAX_WORDS];
   logic [DATA_W-1:0]   wslot_d [MAX_WORDS];
   logic [DATA_W-1:0]   rslot_q [MAX_WORDS];
   logic [DATA_W-1:0]   rslot_d [MAX_WORDS];
   logic [RD_LAT:0]     vld_q, vld_d;
   logic [CNT_W-1:0]    pidx_q [RD_LAT+1];
   logic [CNT_W-1:0]    pidx_d [RD_LAT+1];
   logic                desc_in;
   logic [ADDR_W-1:0]   next_addr;

`ifdef STACK_BURST_DESCEND_EN
   assign desc_in = descend;
`else
   assign desc_in = 1'b0;
`endif

   assign next_addr = desc_q ? (base_q - ADDR_W'(idx_q)) : (base_q + ADDR_W'(idx_q));

   always_comb begin
      state_d     = state_q;
      base_d      = base_q;
      words_d     = words_q;
      idx_d       = idx_q;
      desc_d      = desc_q;
      err_flag_d  = err_flag_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      err_d       = 1'b0;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      ram_wren_d  = 1'b0;
      wslot_d     = wslot_q;
      rslot_d     = rslot_q;
      // Capture pipeline: stage k holds the index whose address went out k cycles ago
      vld_d[0]    = 1'b0;
      pidx_d[0]   = pidx_q[0];
      for (int k = 1; k <= RD_LAT; k++) begin
         vld_d[k]  = vld_q[k-1];
         pidx_d[k] = pidx_q[k-1];
      end
      if (vld_q[RD_LAT]) begin
         rslot_d[pidx_q[RD_LAT][SEL_W-1:0]] = ram_q;
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               base_d  = base_addr;
               words_d = words;
               desc_d  = desc_in;
               for (int s = 0; s < MAX_WORDS; s++) begin
                  wslot_d[s] = wdata_bus[DATA_W*(MAX_WORDS-s)-1 -: DATA_W];
               end
               if ((words == '0) || (words > CNT_W'(MAX_WORDS))) begin
                  err_flag_d = 1'b1;
                  state_d    = FINISH;
               end else begin
                  err_flag_d = 1'b0;
                  busy_d     = 1'b1;
                  idx_d      = CNT_W'(1);
                  ram_addr_d = base_addr;
                  if (dir) begin
                     ram_wren_d  = 1'b1;
                     ram_wdata_d = wdata_bus[DATA_W*MAX_WORDS-1 -: DATA_W];
                     state_d     = WRITE;
                  end else begin
                     vld_d[0]  = 1'b1;
                     pidx_d[0] = '0;
                     state_d   = READ;
                  end
               end
            end
         end
         WRITE: begin
            if (idx_q < words_q) begin
               ram_addr_d  = next_addr;
               ram_wdata_d = wslot_q[idx_q[SEL_W-1:0]];
               ram_wren_d  = 1'b1;
               idx_d       = idx_q + CNT_W'(1);
            end else begin
               state_d = FINISH;
            end
         end
         READ: begin
            if (idx_q < words_q) begin
               ram_addr_d = next_addr;
               vld_d[0]   = 1'b1;
               pidx_d[0]  = idx_q;
               idx_d      = idx_q + CNT_W'(1);
            end
            if (vld_q[RD_LAT] && (pidx_q[RD_LAT] == (words_q - CNT_W'(1)))) begin
               state_d = FINISH;
            end
         end
         FINISH: begin
            done_d  = 1'b1;
            err_d   = err_flag_q;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         base_q      <= '0;
         words_q     <= '0;
         idx_q       <= '0;
         desc_q      <= 1'b0;
         err_flag_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         ram_wren_q  <= 1'b0;
         vld_q       <= '0;
         for (int s = 0; s < MAX_WORDS; s++) begin
            wslot_q[s] <= '0;
            rslot_q[s] <= '0;
         end
         for (int k = 0; k <= RD_LAT; k++) begin
            pidx_q[k] <= '0;
         end
      end else begin
         state_q     <= state_d;
         base_q      <= base_d;
         words_q     <= words_d;
         idx_q       <= idx_d;
         desc_q      <= desc_d;
         err_flag_q  <= err_flag_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
         ram_wren_q  <= ram_wren_d;
         vld_q       <= vld_d;
         wslot_q     <= wslot_d;
         rslot_q     <= rslot_d;
         pidx_q      <= pidx_d;
      end
   end

   generate
      for (genvar s = 0; s < MAX_WORDS; s++) begin : g_rslot
         assign rdata_bus[DATA_W*(MAX_WORDS-s)-1 -: DATA_W] = rslot_q[s];
      end
   endgenerate

   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign ram_addr  = ram_addr_q;
   assign ram_wdata = ram_wdata_q;
   assign ram_wren  = ram_wren_q;

endmodule
`default_nettype wire

// File: tb/tb_stack_burst_engine.sv
`default_nettype none
// ============================================================================
// tb_stack_burst_engine: table-driven bench for stack_burst_engine (RD_LAT=2)
// with a behavioural RAM and an expected-memory/image scoreboard.
// Revision: 1.0
// ============================================================================
module tb_stack_burst_engine;

   localparam int DW = 16;
   localparam int AW = 16;
   localparam int MW = 16;
   localparam int RL = 2;
   localparam int CW = 5;

   logic              clock     = 1'b0;
   logic              reset_n   = 1'b0;
   logic              start     = 1'b0;
   logic              dir       = 1'b0;
`ifdef STACK_BURST_DESCEND_EN
   logic              descend   = 1'b0;
`endif
   logic [AW-1:0]     base_addr = '0;
   logic [CW-1:0]     words     = '0;
   logic [DW*MW-1:0]  wdata_bus = '0;
   logic [DW*MW-1:0]  rdata_bus;
   logic              busy, done, err;
   logic [AW-1:0]     ram_addr;
   logic [DW-1:0]     ram_wdata;
   logic              ram_wren;
   logic [DW-1:0]     ram_q;

   stack_burst_engine #(
      .DATA_W(DW), .ADDR_W(AW), .MAX_WORDS(MW), .RD_LAT(RL), .CNT_W(CW)
   ) dut (
      .clock(clock), .reset_n(reset_n), .start(start), .dir(dir),
`ifdef STACK_BURST_DESCEND_EN
      .descend(descend),
`endif
      .base_addr(base_addr), .words(words), .wdata_bus(wdata_bus),
      .rdata_bus(rdata_bus), .busy(busy), .done(done), .err(err),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wren(ram_wren),
      .ram_q(ram_q)
   );

   always #5 clock = ~clock;

   // Behavioural synchronous RAM with RL cycles of read latency
   logic [DW-1:0] mem    [65536];
   logic [DW-1:0] q_pipe [RL];
   always @(posedge clock) begin
      if (ram_wren) mem[ram_addr] <= ram_wdata;
      q_pipe[0] <= mem[ram_addr];
      for (int k = 1; k < RL; k++) q_pipe[k] <= q_pipe[k-1];
   end
   assign ram_q = q_pipe[RL-1];

   logic [AW-1:0] log_a [$];
   logic [DW-1:0] log_d [$];
   always @(negedge clock) begin
      if (ram_wren) begin
         log_a.push_back(ram_addr);
         log_d.push_back(ram_wdata);
      end
   end

   typedef struct {
      logic        dir;
      logic        desc;
      logic [15:0] base;
      logic [4:0]  words;
      logic [15:0] seed;
      logic [15:0] step;
      logic        mid_start;
      int          exp_lat;
      logic        exp_err;
      string       name;
   } vec_t;

   vec_t          vecs [$];
   logic [DW-1:0] exp_mem [int];
   logic [DW-1:0] exp_img [MW];
   int            tests = 0;
   int            fails = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, expv);
      end
   endtask

   task automatic chk_image(input string name);
      int bad = -1;
      for (int k = 0; k < MW; k++)
         if (bad < 0 && rdata_bus[DW*(MW-k)-1 -: DW] !== exp_img[k]) bad = k;
      tests++;
      if (bad >= 0) begin
         fails++;
         $display("FAIL %s image: slot %0d got %h, expected %h", name, bad,
                  rdata_bus[DW*(MW-bad)-1 -: DW], exp_img[bad]);
      end
   endtask

   task automatic run_vec(input vec_t v);
      int            cyc;
      logic          busy_bad;
      logic          extra;
      logic          legal;
      logic [DW-1:0] dat [MW];
      logic [AW-1:0] a;
      legal = !v.exp_err;
      @(negedge clock);
      log_a.delete();
      log_d.delete();
      for (int k = 0; k < MW; k++) begin
         dat[k] = 16'(v.seed + v.step * 16'(k));
         wdata_bus[DW*(MW-k)-1 -: DW] = dat[k];
      end
      dir       = v.dir;
      base_addr = v.base;
      words     = v.words;
`ifdef STACK_BURST_DESCEND_EN
      descend   = v.desc;
`endif
      start     = 1'b1;
      @(posedge clock);
      @(negedge clock);
      start     = 1'b0;
      dir       = ~dir;
      base_addr = ~base_addr;
      words     = '0;
      wdata_bus = ~wdata_bus;
      cyc       = 0;
      busy_bad  = 1'b0;
      while (!done && cyc < 100) begin
         if (busy !== legal) busy_bad = 1'b1;
         start = v.mid_start && (cyc == 2);
         @(negedge clock);
         cyc++;
      end
      start = 1'b0;
      chk({v.name, " latency"}, 64'(cyc), 64'(v.exp_lat));
      chk({v.name, " err"}, 64'(err), 64'(v.exp_err));
      chk({v.name, " busy"}, 64'({busy, busy_bad}), 64'(0));
      extra = 1'b0;
      repeat (3) begin
         @(negedge clock);
         if (done || busy || err) extra = 1'b1;
      end
      chk({v.name, " single done"}, 64'(extra), 64'(0));
      if (v.dir && legal) begin
         chk({v.name, " write count"}, 64'(log_a.size()), 64'(v.words));
         for (int k = 0; k < int'(v.words); k++) begin
            a = v.desc ? 16'(v.base - 16'(k)) : 16'(v.base + 16'(k));
            exp_mem[int'(a)] = dat[k];
            if (k < log_a.size()) begin
               chk({v.name, " addr"}, 64'(log_a[k]), 64'(a));
               chk({v.name, " data"}, 64'(log_d[k]), 64'(dat[k]));
            end
         end
      end else begin
         chk({v.name, " no writes"}, 64'(log_a.size()), 64'(0));
      end
      if (!v.dir && legal) begin
         for (int k = 0; k < int'(v.words); k++) begin
            a = v.desc ? 16'(v.base - 16'(k)) : 16'(v.base + 16'(k));
            exp_img[k] = exp_mem[int'(a)];
         end
      end
      chk_image(v.name);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic seen_done;
      // dir desc base words seed step mid lat err name
      vecs.push_back('{1'b1, 1'b0, 16'h0010, 5'd3,  16'hAAAA, 16'h1111, 1'b0, 4,  1'b0, "wr3"});
      vecs.push_back('{1'b1, 1'b0, 16'h0020, 5'd16, 16'h1000, 16'h0001, 1'b0, 17, 1'b0, "fill20"});
      vecs.push_back('{1'b0, 1'b0, 16'h0020, 5'd16, 16'h0000, 16'h0000, 1'b0, 19, 1'b0, "rd20"});
      vecs.push_back('{1'b1, 1'b0, 16'h0030, 5'd16, 16'hFFFF, 16'h0000, 1'b0, 17, 1'b0, "fillFF"});
      vecs.push_back('{1'b0, 1'b0, 16'h0030, 5'd16, 16'h0000, 16'h0000, 1'b0, 19, 1'b0, "rdFF"});
      vecs.push_back('{1'b1, 1'b0, 16'h0050, 5'd1,  16'h1234, 16'h0000, 1'b0, 2,  1'b0, "wr1"});
      vecs.push_back('{1'b0, 1'b0, 16'h0050, 5'd1,  16'h0000, 16'h0000, 1'b0, 4,  1'b0, "rd1"});
      vecs.push_back('{1'b1, 1'b0, 16'h0060, 5'd0,  16'h0000, 16'h0000, 1'b0, 1,  1'b1, "err0"});
      vecs.push_back('{1'b1, 1'b0, 16'h0060, 5'd17, 16'h0000, 16'h0000, 1'b0, 1,  1'b1, "err17"});
      vecs.push_back('{1'b0, 1'b0, 16'h0060, 5'd31, 16'h0000, 16'h0000, 1'b0, 1,  1'b1, "err31rd"});
      vecs.push_back('{1'b1, 1'b0, 16'hFFFE, 5'd4,  16'h5A00, 16'h0003, 1'b1, 5,  1'b0, "wrapwr"});
      vecs.push_back('{1'b0, 1'b0, 16'hFFFE, 5'd4,  16'h0000, 16'h0000, 1'b1, 7,  1'b0, "wraprd"});
`ifdef STACK_BURST_DESCEND_EN
      vecs.push_back('{1'b1, 1'b1, 16'h0100, 5'd3,  16'h7700, 16'h0001, 1'b0, 4,  1'b0, "descwr"});
      vecs.push_back('{1'b0, 1'b1, 16'h0100, 5'd3,  16'h0000, 16'h0000, 1'b0, 6,  1'b0, "descrd"});
`endif
      for (int k = 0; k < MW; k++) exp_img[k] = '0;

      repeat (2) @(negedge clock);
      chk("reset ctl", 64'({busy, done, err, ram_wren}), 64'(0));
      chk("reset ram bus", 64'({ram_addr, ram_wdata}), 64'(0));
      chk_image("reset");
      reset_n = 1'b1;

      foreach (vecs[i]) run_vec(vecs[i]);

      // Abort an 8-word write two cycles in
      @(negedge clock);
      log_a.delete();
      log_d.delete();
      dir = 1'b1; base_addr = 16'h0080; words = 5'd8;
      for (int k = 0; k < MW; k++) wdata_bus[DW*(MW-k)-1 -: DW] = 16'(16'h4000 + 16'(k));
      start = 1'b1;
      @(posedge clock);
      @(negedge clock);
      start = 1'b0;
      repeat (2) @(negedge clock);
      chk("pre-reset wren", 64'(ram_wren), 64'(1));
      #2 reset_n = 1'b0;
      #1;
      chk("async reset wren", 64'(ram_wren), 64'(0));
      chk("async reset busy", 64'(busy), 64'(0));
      chk("async reset rdata", 64'(rdata_bus != '0), 64'(0));
      seen_done = 1'b0;
      repeat (3) begin
         @(negedge clock);
         if (done) seen_done = 1'b1;
      end
      chk("no done after abort", 64'(seen_done), 64'(0));
      reset_n = 1'b1;
      for (int k = 0; k < MW; k++) exp_img[k] = '0;

      run_vec('{1'b1, 1'b0, 16'h0090, 5'd2, 16'hC0DE, 16'h0101, 1'b0, 3, 1'b0, "postrst wr"});
      run_vec('{1'b0, 1'b0, 16'h0090, 5'd2, 16'h0000, 16'h0000, 1'b0, 5, 1'b0, "postrst rd"});

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
